imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Byte-stream program loader that writes instruction memory before the single-cycle core runs.
- Receives a framed byte stream over a valid/ready handshake and assembles 32-bit little-endian instruction words.
- Writes each word to the instruction-memory write port at word addresses 0..N-1. The core fetches words with PC stepping by 1.
- Holds the core in reset through its own active-low reset output until a frame loads with a correct checksum.

Parameters:
- INST_W, 32, instruction width in bits; fixed at 4 bytes.
- DEPTH, 80, instruction-memory depth in words.
- ADDR_W, 64, width of the write address, matching the core's PC width.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  loader accepts the byte this cycle. A transfer occurs when in_valid and in_ready are both high.
- wr_en  out  1  one-cycle instruction-memory write strobe.
- wr_addr  out  ADDR_W  word address of the write.
- wr_data  out  INST_W  instruction word to write.
- cpu_rst_n  out  1  active-low reset to the core.
- busy  out  1  a frame is in progress.
- done  out  1  last frame loaded successfully.
- error  out  1  last frame was rejected.

Behaviour:
- Reset values (RST low, asynchronous):
  - state=IDLE, in_ready=1, wr_en=0, wr_addr=0, wr_data=0.
  - cpu_rst_n=0, busy=0, done=0, error=0.
  - Internal word count, byte index and checksum all 0.
- Frame format: 0xA5 header, LEN lo, LEN hi (N words, 16-bit), N×4 data bytes (LSB first), 1 checksum byte. The checksum is the XOR of all data bytes only.
- All outputs are registered. wr_en pulses exactly one cycle, in the cycle after the 4th byte of a word is accepted.
- States and transitions:
  - IDLE/DONE/ERR: accept bytes and discard them unless the byte is 0xA5.
    - On 0xA5: go to LEN0; busy=1, done=0, error=0, cpu_rst_n=0; clear the count and checksum.
  - LEN0: latch the low byte of N, then go to LEN1.
  - LEN1: latch the high byte of N.
    - If N>DEPTH: go to ERR (error=1, busy=0).
    - If N==0: go to CHK.
    - Otherwise: go to DATA.
  - DATA:
    - Shift the byte into position byte_idx (0..3) and XOR it into the checksum.
    - On byte_idx==3: go to WR.
  - WR (one cycle):
    - wr_en=1, wr_addr = current word index, wr_data = assembled word, in_ready=0.
    - Then increment the word index. If index==N go to CHK, else go to DATA.
  - CHK: accept one byte.
    - If it equals the checksum: go to DONE (done=1, busy=0, cpu_rst_n=1 from the next cycle).
    - Otherwise: go to ERR (error=1, busy=0; cpu_rst_n stays 0).
- in_ready is 1 in every state except WR. in_valid with in_ready=0 is not a transfer; the source must hold the byte.
- A new 0xA5 in DONE drops cpu_rst_n to 0 in the cycle after acceptance, which starts a reload.
- A 0xA5 inside LEN/DATA/CHK is ordinary data; there is no resynchronisation mid-frame.
- Words already written before an error stay in memory. The core stays in reset until a later frame succeeds.
- RST low mid-frame aborts the frame immediately: all outputs return to their reset values and no partial write is issued.
- wr_addr is the zero-extended 16-bit word index.

Decomposition:
- Shared package imem_loader_pkg holds:
  - the state enum (IDLE, LEN0, LEN1, DATA, WR, CHK, DONE, ERR);
  - constant HDR_BYTE=8'hA5;
  - constant BYTES_PER_WORD=4.
- One natural sub-module: word_assembler.
  - Takes byte, strobe and clear inputs.
  - Produces the 32-bit LE word, a word_full flag and a running XOR.
  - Instantiated once. The FSM stays in imem_loader.

Test Plan:
- Stream A5 01 00 93 00 50 00 C3 -> one wr_en pulse with addr=0, data=32'h00500093; then done=1, cpu_rst_n=1, error=0.
- Stream A5 02 00 93 00 50 00 33 81 10 00 61 ->
  - addr0=32'h00500093, addr1=32'h00108133;
  - exactly 2 wr_en pulses, in_ready=0 in each WR cycle;
  - done=1.
- Same 1-word frame but checksum C2 -> word written, error=1, done=0, cpu_rst_n stays 0.
- A5 51 00 (N=81 > DEPTH=80) -> error=1 after LEN1, no wr_en; following data bytes are discarded until the next 0xA5.
- Case A: A5 00 00 00 -> no writes, done=1.
  Case B: garbage bytes 12 34 while IDLE -> ignored, no state change.
- Case A: assert RST low after 2 data bytes of a frame -> outputs reset, no wr_en.
  Case B: a subsequent full valid frame loads correctly.
  Case C: toggle in_valid with gaps -> identical writes.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared constants and types for the instruction-memory byte-stream loader.
package imem_loader_pkg;

  localparam int INST_W         = 32;
  localparam int DEPTH          = 80;
  localparam int ADDR_W         = 64;
  localparam int CNT_W          = 16;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN0 = 3'd1,
    LEN1 = 3'd2,
    DATA = 3'd3,
    WR   = 3'd4,
    CHK  = 3'd5,
    DONE = 3'd6,
    ERR  = 3'd7
  } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Signal bundle between the loader, its byte source, instruction memory and core.
// Byte handshake: a byte moves only on a clock edge where in_valid and in_ready
// are both high; while in_valid is high and in_ready is low the source holds
// in_data unchanged, and in_ready never depends combinationally on in_valid.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [INST_W-1:0] wr_data;
  logic              cpu_rst_n;
  logic              busy;
  logic              done;
  logic              error;
  state_e            dbg_state;

  // Byte source / observer side.
  modport master (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data, cpu_rst_n, busy, done, error,
    input  dbg_state
  );

  // Loader side.
  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data, cpu_rst_n, busy, done, error,
    output dbg_state
  );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Gathers four little-endian bytes into a word and keeps a running XOR of them.
// word_full_o is high when the byte presented now is the last of a word; word_o
// is then the complete word including that byte.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              strobe_i,
  input  logic [7:0]        byte_i,
  output logic [INST_W-1:0] word_o,
  output logic              word_full_o,
  output logic [7:0]        xor_o
);

  logic [1:0]  idx_q;
  logic [23:0] low_q;
  logic [7:0]  xor_q;

  // Byte position, lower three bytes of the word and checksum accumulation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= 2'd0;
      low_q <= 24'd0;
      xor_q <= 8'd0;
    end else if (clear_i) begin
      idx_q <= 2'd0;
      low_q <= 24'd0;
      xor_q <= 8'd0;
    end else if (strobe_i) begin
      case (idx_q)
        2'd0:    low_q[7:0]   <= byte_i;
        2'd1:    low_q[15:8]  <= byte_i;
        2'd2:    low_q[23:16] <= byte_i;
        default: ;
      endcase
      idx_q <= idx_q + 2'd1;
      xor_q <= xor_q ^ byte_i;
    end
  end

  assign word_o      = {byte_i, low_q};
  assign word_full_o = (idx_q == 2'(BYTES_PER_WORD - 1));
  assign xor_o       = xor_q;

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: writes instruction memory and holds the core in
// reset until a frame with a correct checksum has been loaded.
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic         CLK,
  input  logic         RST,
  imem_loader_if.slave bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic              in_ready_q, in_ready_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [INST_W-1:0] wr_data_q, wr_data_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              accept;
  logic              is_hdr;
  logic              waiting;
  logic              asm_clear;
  logic              asm_strobe;
  logic [INST_W-1:0] asm_word;
  logic              asm_full;
  logic [7:0]        asm_xor;
  logic [CNT_W-1:0]  n_full;

  assign accept     = bus.in_valid && in_ready_q;
  assign is_hdr     = (bus.in_data == HDR_BYTE);
  assign waiting    = (state_q == IDLE) || (state_q == DONE) || (state_q == ERR);
  assign asm_clear  = accept && waiting && is_hdr;
  assign asm_strobe = accept && (state_q == DATA);
  assign n_full     = {bus.in_data, n_q[7:0]};

  word_assembler u_asm (
    .clk_i       (CLK),
    .rst_ni      (RST),
    .clear_i     (asm_clear),
    .strobe_i    (asm_strobe),
    .byte_i      (bus.in_data),
    .word_o      (asm_word),
    .word_full_o (asm_full),
    .xor_o       (asm_xor)
  );

  // Register every output together with the FSM state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      n_q         <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cpu_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // Frame parser: next state and next registered outputs.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    idx_d       = idx_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    cpu_rst_n_d = cpu_rst_n_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        // Anything but a header byte is dropped here.
        if (accept && is_hdr) begin
          state_d     = LEN0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          error_d     = 1'b0;
          cpu_rst_n_d = 1'b0;
          idx_d       = '0;
          n_d         = '0;
        end
      end
      LEN0: begin
        if (accept) begin
          n_d[7:0] = bus.in_data;
          state_d  = LEN1;
        end
      end
      LEN1: begin
        if (accept) begin
          n_d = n_full;
          if (n_full > CNT_W'(DEPTH)) begin
            state_d = ERR;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end else if (n_full == '0) begin
            state_d = CHK;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept && asm_full) begin
          state_d   = WR;
          wr_en_d   = 1'b1;
          wr_addr_d = ADDR_W'(idx_q);
          wr_data_d = asm_word;
        end
      end
      WR: begin
        idx_d   = idx_q + 1'b1;
        state_d = (idx_q + 1'b1 == n_q) ? CHK : DATA;
      end
      CHK: begin
        if (accept) begin
          busy_d = 1'b0;
          if (bus.in_data == asm_xor) begin
            state_d     = DONE;
            done_d      = 1'b1;
            cpu_rst_n_d = 1'b1;
          end else begin
            state_d = ERR;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The single write cycle is the only time no byte is taken.
    in_ready_d = (state_d != WR);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.cpu_rst_n = cpu_rst_n_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames with hand-computed words and checksums.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  imem_loader_if bus();

  imem_loader dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int vec_cnt = 0;
  int err_cnt = 0;
  int wr_cnt  = 0;
  logic [95:0] exp_q[$];   // {addr[63:0], data[31:0]}

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every write strobe is matched against the next expected word.
  always @(negedge CLK) begin
    logic [95:0] e;
    if (bus.wr_en === 1'b1) begin
      wr_cnt++;
      chk("wr_in_ready_low", 64'(bus.in_ready), 64'd0);
      chk("wr_expected_pending", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", bus.wr_addr, e[95:32]);
        chk("wr_data", 64'(bus.wr_data), 64'(e[31:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 16) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 16) chk("ready_timeout", 64'(bus.in_ready), 64'd1);
    @(negedge CLK);
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] f[$], input int max_gap);
    foreach (f[i]) send_byte(f[i], (max_gap == 0) ? 0 : int'($urandom_range(1, max_gap)));
  endtask

  task automatic expect_wr(input logic [63:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic chk_status(input string tag, input logic d, input logic e,
                            input logic crn, input logic bsy, input state_e st);
    chk({tag, "_done"},      64'(bus.done),      64'(d));
    chk({tag, "_error"},     64'(bus.error),     64'(e));
    chk({tag, "_cpu_rst_n"}, 64'(bus.cpu_rst_n), 64'(crn));
    chk({tag, "_busy"},      64'(bus.busy),      64'(bsy));
    chk({tag, "_state"},     64'(bus.dbg_state), 64'(st));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    chk({tag, "_wr_en"},    64'(bus.wr_en),    64'd0);
    chk({tag, "_wr_addr"},  bus.wr_addr,       64'd0);
    chk({tag, "_wr_data"},  64'(bus.wr_data),  64'd0);
    chk_status(tag, 1'b0, 1'b0, 1'b0, 1'b0, IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] frm[$];
    int w0;

    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;

    // Reset state.
    repeat (3) @(negedge CLK);
    chk_reset_vals("rst");
    RST = 1'b1;
    @(negedge CLK);

    // One-word frame.
    w0 = wr_cnt;
    expect_wr(64'd0, 32'h00500093);
    frm = '{8'hA5, 8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC3};
    send_frame(frm, 0);
    chk_status("one_word", 1'b1, 1'b0, 1'b1, 1'b0, DONE);
    chk("one_word_writes", 64'(wr_cnt - w0), 64'd1);
    chk("one_word_q_empty", 64'(exp_q.size()), 64'd0);

    // Reload from DONE: header drops the core reset.
    send_byte(8'hA5, 0);
    chk_status("reload_hdr", 1'b0, 1'b0, 1'b0, 1'b1, LEN0);

    // Two-word frame (header already sent).
    w0 = wr_cnt;
    expect_wr(64'd0, 32'h00500093);
    expect_wr(64'd1, 32'h00108133);
    frm = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
            8'h33, 8'h81, 8'h10, 8'h00, 8'h61};
    send_frame(frm, 0);
    chk_status("two_word", 1'b1, 1'b0, 1'b1, 1'b0, DONE);
    chk("two_word_writes", 64'(wr_cnt - w0), 64'd2);
    chk("two_word_q_empty", 64'(exp_q.size()), 64'd0);

    // Bad checksum: word still written, frame rejected.
    w0 = wr_cnt;
    expect_wr(64'd0, 32'h00500093);
    frm = '{8'hA5, 8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC2};
    send_frame(frm, 0);
    chk_status("bad_cksum", 1'b0, 1'b1, 1'b0, 1'b0, ERR);
    chk("bad_cksum_writes", 64'(wr_cnt - w0), 64'd1);

    // Oversize length, then trailing bytes are discarded.
    w0 = wr_cnt;
    frm = '{8'hA5, 8'h51, 8'h00};
    send_frame(frm, 0);
    chk_status("oversize", 1'b0, 1'b1, 1'b0, 1'b0, ERR);
    frm = '{8'h93, 8'h00, 8'h50, 8'h00, 8'hC3};
    send_frame(frm, 0);
    chk_status("oversize_tail", 1'b0, 1'b1, 1'b0, 1'b0, ERR);
    chk("oversize_writes", 64'(wr_cnt - w0), 64'd0);

    // Zero-length frame.
    w0 = wr_cnt;
    frm = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame(frm, 0);
    chk_status("empty", 1'b1, 1'b0, 1'b1, 1'b0, DONE);
    chk("empty_writes", 64'(wr_cnt - w0), 64'd0);

    // Garbage while IDLE after a reset.
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    frm = '{8'h12, 8'h34};
    send_frame(frm, 0);
    chk_reset_vals("garbage");

    // Reset in the middle of a frame's data.
    w0 = wr_cnt;
    frm = '{8'hA5, 8'h01, 8'h00, 8'h93, 8'h00};
    send_frame(frm, 0);
    chk_status("pre_abort", 1'b0, 1'b0, 1'b0, 1'b1, DATA);
    #2 RST = 1'b0;
    #1 chk_reset_vals("abort");
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk_reset_vals("post_abort");
    chk("abort_writes", 64'(wr_cnt - w0), 64'd0);

    // Full frame after the abort, with gaps between bytes.
    w0 = wr_cnt;
    expect_wr(64'd0, 32'h00500093);
    expect_wr(64'd1, 32'h00108133);
    frm = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
            8'h33, 8'h81, 8'h10, 8'h00, 8'h61};
    send_frame(frm, 3);
    chk_status("gapped", 1'b1, 1'b0, 1'b1, 1'b0, DONE);
    chk("gapped_writes", 64'(wr_cnt - w0), 64'd2);
    chk("gapped_q_empty", 64'(exp_q.size()), 64'd0);

    repeat (3) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
